// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, display_on and lock status from incoming VGA hsync/vsync.
// Define VGA_SYNC_DECODER_STATS_EN to add the measured-period and error-count outputs.
module vga_sync_decoder #(
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_LINES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        display_on,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_error
`ifdef VGA_SYNC_DECODER_STATS_EN
    ,
    output logic [11:0] meas_h_period,
    output logic [10:0] meas_v_lines,
    output logic [7:0]  err_count
`endif
);

    localparam int GW = $clog2(LOCK_LINES + 1);

    localparam logic [9:0]    HV_L    = 10'(H_VISIBLE);
    localparam logic [9:0]    HSS_L   = 10'(H_SYNC_START);
    localparam logic [9:0]    HT_M1   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    VV_L    = 10'(V_VISIBLE);
    localparam logic [9:0]    VSS_L   = 10'(V_SYNC_START);
    localparam logic [9:0]    VT_M1   = 10'(V_TOTAL - 1);
    localparam logic [11:0]   HT_L    = 12'(H_TOTAL);
    localparam logic [11:0]   HTO_L   = 12'(2 * H_TOTAL);
    localparam logic [10:0]   VT_L    = 11'(V_TOTAL);
    localparam logic [GW-1:0] GOOD_M1 = GW'(LOCK_LINES - 1);

    typedef enum logic [1:0] {SEARCH, ACQ_H, ACQ_V, LOCKED} state_t;

    state_t          state;
    logic            hs_prev, vs_prev;
    logic [11:0]     h_period;
    logic [10:0]     line_cnt;
    logic [GW-1:0]   good_cnt;
    logic            v_seen;

    logic            h_edge, v_edge, h_good, v_good, timeout;
    logic [9:0]      nx, ny;

    assign h_edge  = hsync && !hs_prev;
    assign v_edge  = vsync && !vs_prev;
    assign h_good  = (h_period == HT_L);
    assign v_good  = (line_cnt == VT_L);
    assign timeout = (state != SEARCH) && (h_period >= HTO_L);

    // Free-running position, snapped to the sync start coordinates on every rising edge.
    always_comb begin
        nx = (pos_x == HT_M1) ? 10'd0 : pos_x + 10'd1;
        ny = pos_y;
        if (h_edge)
            nx = HSS_L;
        if (v_edge)
            ny = VSS_L;
        else if (!h_edge && pos_x == HT_M1)
            ny = (pos_y == VT_M1) ? 10'd0 : pos_y + 10'd1;
    end

    assign display_on = locked && (pos_x < HV_L) && (pos_y < VV_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            pos_x       <= '0;
            pos_y       <= '0;
            h_period    <= '0;
            line_cnt    <= '0;
            good_cnt    <= '0;
            v_seen      <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            hs_prev     <= hsync;
            vs_prev     <= vsync;
            pos_x       <= nx;
            pos_y       <= ny;
            locked      <= (state == LOCKED);
            frame_start <= (state == LOCKED) && (nx == 10'd0) && (ny == 10'd0);
            sync_error  <= 1'b0;

            if (h_edge)
                h_period <= 12'd1;
            else if (h_period != 12'hfff)
                h_period <= h_period + 12'd1;

            if (v_edge)
                line_cnt <= '0;
            else if (h_edge && line_cnt != 11'h7ff)
                line_cnt <= line_cnt + 11'd1;

            // Timeout outranks edge checks; a good h_edge lets a same-cycle v_edge through.
            if (timeout) begin
                state      <= SEARCH;
                sync_error <= 1'b1;
            end else begin
                case (state)
                    SEARCH: if (h_edge) begin
                        state    <= ACQ_H;
                        good_cnt <= '0;
                    end
                    ACQ_H: if (h_edge) begin
                        if (h_good) begin
                            good_cnt <= good_cnt + 1'b1;
                            if (good_cnt == GOOD_M1) begin
                                state  <= ACQ_V;
                                v_seen <= 1'b0;
                            end
                        end else begin
                            good_cnt   <= '0;
                            sync_error <= 1'b1;
                        end
                    end
                    ACQ_V: begin
                        if (h_edge && !h_good) begin
                            state      <= ACQ_H;
                            good_cnt   <= '0;
                            sync_error <= 1'b1;
                        end else if (v_edge) begin
                            if (!v_seen)
                                v_seen <= 1'b1;
                            else if (v_good)
                                state <= LOCKED;
                            else
                                sync_error <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (h_edge && !h_good) begin
                            state      <= ACQ_H;
                            good_cnt   <= '0;
                            sync_error <= 1'b1;
                        end else if (v_edge && !v_good) begin
                            state      <= ACQ_V;
                            v_seen     <= 1'b1;
                            sync_error <= 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef VGA_SYNC_DECODER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            meas_h_period <= '0;
            meas_v_lines  <= '0;
            err_count     <= '0;
        end else begin
            if (h_edge)
                meas_h_period <= h_period;
            if (v_edge)
                meas_v_lines <= line_cnt;
            if (sync_error && err_count != 8'hff)
                err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced-size timing generator drives the decoder and a
// queue of generator positions is compared against the recovered position one clock later.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    localparam int HV = 16, HSS = 18, HSE = 22, HT = 26;
    localparam int VV = 10, VSS = 12, VSE = 14, VT = 16;
    localparam int LL = 4;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] pos_x, pos_y;
    logic       display_on, locked, frame_start, sync_error;
`ifdef VGA_SYNC_DECODER_STATS_EN
    logic [11:0] meas_h_period;
    logic [10:0] meas_v_lines;
    logic [7:0]  err_count;
`endif

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_TOTAL(VT), .LOCK_LINES(LL)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .pos_x(pos_x), .pos_y(pos_y), .display_on(display_on), .locked(locked),
        .frame_start(frame_start), .sync_error(sync_error)
`ifdef VGA_SYNC_DECODER_STATS_EN
        , .meas_h_period(meas_h_period), .meas_v_lines(meas_v_lines), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; } exp_t;
    exp_t sb[$];

    int gx = 0, gy = 0, line_len = HT, frame_len = VT;
    bit hs_kill = 1'b0, chk_pos = 1'b0;
    int n_chk = 0, n_err = 0, n_serr = 0, n_vedge = 0, cyc = 0;

    // Present the generator's current position on the sync lines and queue it as the
    // position the decoder must report one clock later.
    function automatic void drive_gen();
        logic vs_n;
        exp_t e;
        vs_n = (gy >= VSS) && (gy < VSE);
        if (vs_n && !vsync)
            n_vedge++;
        vsync = vs_n;
        hsync = !hs_kill && (gx >= HSS) && (gx < HSE);
        e.x = gx;
        e.y = gy;
        sb.push_back(e);
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (chk_pos) begin
            n_chk++;
            if (pos_x !== 10'(e.x) || pos_y !== 10'(e.y)) begin
                n_err++;
                chk_pos = 1'b0;
                $display("FAIL pos_track cyc=%0d got (%0d,%0d) want (%0d,%0d)",
                         cyc, pos_x, pos_y, e.x, e.y);
            end
        end
        if (sync_error)
            n_serr++;
        cyc++;
        gx++;
        if (gx >= line_len) begin
            gx = 0;
            line_len = HT;
            gy++;
            if (gy >= frame_len) begin
                gy = 0;
                frame_len = VT;
            end
        end
        drive_gen();
    endtask

    task automatic wait_lock(input int bound);
        int t = 0;
        while (locked !== 1'b1 && t < bound) begin
            tick();
            t++;
        end
    endtask

    task automatic wait_gen(input int x, input int y);
        int t = 0;
        while (!(gx == x && (y < 0 || gy == y)) && t < 2 * FRAME) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_chk++;
        if (pos_x !== 10'd0 || pos_y !== 10'd0) begin
            n_err++;
            $display("FAIL reset_pos got (%0d,%0d) want (0,0)", pos_x, pos_y);
        end
        n_chk++;
        if ({locked, display_on, frame_start, sync_error} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got %b want 0000", {locked, display_on, frame_start, sync_error});
        end
        gx = HT - 1;
        gy = VT - 1;
        reset = 1'b0;
    endtask

    task automatic test_lock_and_frames();
        int s, fs_cnt, don, last;
        wait_lock(2 * FRAME);
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL initial_lock got locked=%b want 1 within %0d clks", locked, 2 * FRAME);
        end
        n_chk++;
        if (pos_y !== 10'(VSS)) begin
            n_err++;
            $display("FAIL lock_pos_y got %0d want %0d", pos_y, VSS);
        end
        chk_pos = 1'b1;
        s = n_serr;
        fs_cnt = 0;
        don = 0;
        last = -1;
        repeat (3 * FRAME) begin
            tick();
            if (display_on)
                don++;
            if (frame_start) begin
                fs_cnt++;
                n_chk++;
                if (pos_x !== 10'd0 || pos_y !== 10'd0) begin
                    n_err++;
                    $display("FAIL frame_start_pos got (%0d,%0d) want (0,0)", pos_x, pos_y);
                end
                if (last >= 0) begin
                    n_chk++;
                    if (cyc - last != FRAME) begin
                        n_err++;
                        $display("FAIL frame_start_gap got %0d want %0d", cyc - last, FRAME);
                    end
                end
                last = cyc;
            end
        end
        n_chk++;
        if (fs_cnt != 3) begin
            n_err++;
            $display("FAIL frame_start_count got %0d want 3", fs_cnt);
        end
        n_chk++;
        if (don != 3 * HV * VV) begin
            n_err++;
            $display("FAIL display_on_count got %0d want %0d", don, 3 * HV * VV);
        end
        n_chk++;
        if (n_serr != s || locked !== 1'b1) begin
            n_err++;
            $display("FAIL locked_clean got errors=%0d locked=%b want 0 and 1", n_serr - s, locked);
        end
    endtask

    task automatic test_timeout();
        int s;
        wait_gen(0, 0);
        chk_pos = 1'b0;
        s = n_serr;
        hs_kill = 1'b1;
        repeat (2 * HT) tick();
        hs_kill = 1'b0;
        n_chk++;
        if (n_serr - s != 1 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL timeout got errors=%0d locked=%b want 1 and 0", n_serr - s, locked);
        end
        wait_lock(2 * FRAME);
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_relock got locked=%b want 1", locked);
        end
        chk_pos = 1'b1;
        s = n_serr;
        repeat (FRAME) tick();
        n_chk++;
        if (n_serr != s) begin
            n_err++;
            $display("FAIL timeout_after got errors=%0d want 0", n_serr - s);
        end
    endtask

    task automatic test_short_line();
        int s, v0, t;
        wait_gen(0, 1);
        chk_pos = 1'b0;
        s = n_serr;
        line_len = HT - 1;
        t = 0;
        while (sync_error !== 1'b1 && t < 3 * HT) begin
            tick();
            t++;
        end
        n_chk++;
        if (sync_error !== 1'b1) begin
            n_err++;
            $display("FAIL short_line_err got sync_error=%b want 1", sync_error);
        end
        tick();
        n_chk++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL short_line_unlock got locked=%b want 0", locked);
        end
        v0 = n_vedge;
        wait_lock(2 * FRAME);
        n_chk++;
        if (locked !== 1'b1 || n_vedge - v0 != 2) begin
            n_err++;
            $display("FAIL short_line_relock got locked=%b vedges=%0d want 1 and 2", locked, n_vedge - v0);
        end
        n_chk++;
        if (n_serr - s != 1) begin
            n_err++;
            $display("FAIL short_line_errcnt got %0d want 1", n_serr - s);
        end
        chk_pos = 1'b1;
        repeat (4 * HT) tick();
    endtask

    task automatic test_short_frame();
        int s, v0, t;
        wait_gen(0, VSS + 1);
        chk_pos = 1'b0;
        s = n_serr;
        frame_len = VT - 1;
        t = 0;
        while (sync_error !== 1'b1 && t < 2 * FRAME) begin
            tick();
            t++;
        end
        n_chk++;
        if (sync_error !== 1'b1 || pos_y !== 10'(VSS)) begin
            n_err++;
            $display("FAIL short_frame_err got sync_error=%b pos_y=%0d want 1 and %0d", sync_error, pos_y, VSS);
        end
        v0 = n_vedge;
        tick();
        n_chk++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL short_frame_unlock got locked=%b want 0", locked);
        end
        wait_lock(2 * FRAME);
        n_chk++;
        if (locked !== 1'b1 || n_vedge - v0 != 1 || n_serr - s != 1) begin
            n_err++;
            $display("FAIL short_frame_relock got locked=%b vedges=%0d errors=%0d want 1, 1, 1",
                     locked, n_vedge - v0, n_serr - s);
        end
        chk_pos = 1'b1;
        repeat (FRAME) tick();
    endtask

    task automatic test_reset_mid();
        wait_gen(HSS + 1, -1);
        chk_pos = 1'b0;
        reset = 1'b1;
        tick();
        n_chk++;
        if (pos_x !== 10'd0 || pos_y !== 10'd0 ||
            {locked, display_on, frame_start, sync_error} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid got pos=(%0d,%0d) flags=%b want (0,0) 0000",
                     pos_x, pos_y, {locked, display_on, frame_start, sync_error});
        end
        reset = 1'b0;
        tick();
        n_chk++;
        if (pos_x !== 10'd1 || pos_y !== 10'd0) begin
            n_err++;
            $display("FAIL reset_no_edge got (%0d,%0d) want (1,0)", pos_x, pos_y);
        end
        n_serr = 0;
        wait_lock(3 * FRAME);
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL reset_relock got locked=%b want 1", locked);
        end
        chk_pos = 1'b1;
        repeat (FRAME) tick();
    endtask

`ifdef VGA_SYNC_DECODER_STATS_EN
    task automatic test_stats();
        int s;
        n_chk++;
        if (meas_h_period !== 12'(HT) || meas_v_lines !== 11'(VT)) begin
            n_err++;
            $display("FAIL stats_meas got %0d/%0d want %0d/%0d", meas_h_period, meas_v_lines, HT, VT);
        end
        n_chk++;
        if (err_count !== 8'(n_serr)) begin
            n_err++;
            $display("FAIL stats_err_clean got %0d want %0d", err_count, n_serr);
        end
        chk_pos = 1'b0;
        s = n_serr;
        wait_gen(0, -1);
        repeat (10) begin
            line_len = HT - 1;
            tick();
            wait_gen(0, -1);
        end
        n_chk++;
        if (err_count !== 8'(n_serr) || n_serr - s < 9) begin
            n_err++;
            $display("FAIL stats_err_incr got %0d want %0d", err_count, n_serr);
        end
        repeat (280) begin
            line_len = HT - 1;
            tick();
            wait_gen(0, -1);
        end
        n_chk++;
        if (err_count !== 8'hff || n_serr < 255) begin
            n_err++;
            $display("FAIL stats_err_sat got %0d (errors seen %0d) want 255", err_count, n_serr);
        end
    endtask
`endif

    initial begin
        drive_gen();
        test_reset();
        test_lock_and_frames();
        test_timeout();
        test_short_line();
        test_short_frame();
        test_reset_mid();
`ifdef VGA_SYNC_DECODER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
